minirisc_result_uart_tx: RTL and testbench

- Downstream stage of the mini-RISC accumulator core: consumes each 8-bit result word the core produces and transmits it off-chip as a UART 8N1 frame.
- Holds results in a small FIFO so result bursts are not lost while a frame is on the wire.
- Sits between the core's result output and a dedicated output pin.

---
 rtl/minirisc_result_uart_tx_if.sv | 19 +
 rtl/minirisc_result_uart_tx.sv | 165 ++++++++++++++++
 tb/tb_minirisc_result_uart_tx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/minirisc_result_uart_tx_if.sv
// rtl/minirisc_result_uart_tx_if.sv - result handshake between the core and the UART transmitter
// The master side (core) drives the word and valid; the slave side (transmitter) returns ready.
interface minirisc_result_uart_tx_if;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;

  modport master (
    output res_data,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_data,
    input  res_valid,
    output res_ready
  );
endinterface

// File: rtl/minirisc_result_uart_tx.sv
// rtl/minirisc_result_uart_tx.sv - result FIFO feeding a UART 8N1 serializer
// A frame is popped as soon as the line is free, so back-to-back words go out with no idle gap.
module minirisc_result_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  minirisc_result_uart_tx_if.slave   res,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];

  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            bit_done;

  // Ready depends only on the registered count, so a full FIFO refuses even while popping.
  assign res.res_ready = ena && (count_q != CW'(DEPTH));
  assign push          = res.res_valid && res.res_ready;
  assign fifo_empty    = (count_q == '0);
  assign bit_done      = (timer_q == 8'(CLKS_PER_BIT - 1));

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_count = count_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          tx_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            timer_d = 8'd0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            tx_d      = shift_q[0];
            bit_idx_d = 3'd0;
            timer_d   = 8'd0;
            state_d   = S_DATA;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            timer_d = 8'd0;
            if (bit_idx_q == 3'd7) begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
              shift_d   = {1'b0, shift_q[7:1]};
              tx_d      = shift_q[1];
            end
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            timer_d = 8'd0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              tx_d    = 1'b0;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        default: begin
          state_d   = S_IDLE;
          tx_d      = 1'b1;
          timer_d   = 8'd0;
          bit_idx_d = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = res.res_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_minirisc_result_uart_tx.sv
// tb/tb_minirisc_result_uart_tx.sv - scoreboard bench for the result UART transmitter
// Accepted words queue up as expected frames; a line monitor decodes tx per active clock tick.
module tb_minirisc_result_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  minirisc_result_uart_tx_if res_if();

  minirisc_result_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .res        (res_if),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  byte unsigned exp_q[$];
  logic       n_rst  = 1'b1;
  logic       n_tick = 1'b0;
  logic       n_acc  = 1'b0;
  logic [7:0] n_data = 8'd0;
  logic       in_frame = 1'b0;
  logic [7:0] cur = 8'd0;
  logic       last_tx = 1'b1;
  int k = 0, bad = 0, frames = 0;
  int gap_err = 0, frz_err = 0, unexp = 0, rdy_err = 0;

  // Pre-edge snapshot: inputs change 2 time units after posedge, so negedge sees settled values.
  always @(negedge clk) begin
    n_rst  = rst;
    n_tick = !rst && ena;
    n_acc  = !rst && res_if.res_valid && res_if.res_ready;
    n_data = res_if.res_data;
    if (res_if.res_ready !== (ena && (fifo_count != 3'(DEPTH)))) rdy_err++;
  end

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (n_rst) begin
      in_frame = 1'b0;
      exp_q.delete();
    end else if (n_tick) begin
      if (in_frame) begin
        if (tx !== frame_bit(cur, k / CPB)) bad++;
        k++;
        if (k == FRAME) begin
          in_frame = 1'b0;
          frames++;
          checks++;
          if (bad != 0) begin
            failures++;
            $display("FAIL frame: byte %02h had %0d wrong bit ticks, required 0", cur, bad);
          end
        end
      end else if (tx === 1'b0) begin
        if (exp_q.size() == 0) unexp++;
        else begin
          cur = exp_q.pop_front();
          in_frame = 1'b1;
          k = 1;
          bad = 0;
        end
      end else if (exp_q.size() != 0) begin
        gap_err++;
      end
      if (n_acc) exp_q.push_back(n_data);
    end else if (tx !== last_tx) begin
      frz_err++;
    end
    last_tx = tx;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy !== 1'b0 || in_frame) && n < budget) begin
      step();
      n++;
    end
    check("wait_idle_in_budget", (n < budget) ? 1 : 0, 1);
  endtask

  task automatic push_word(input logic [7:0] d);
    res_if.res_data  = d;
    res_if.res_valid = 1'b1;
    step();
    res_if.res_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int peak, sent, seen_full, n, tx_low;
    logic acc, tx_f;
    logic [2:0] cnt_f;
    logic [7:0] b2b [4];

    res_if.res_valid = 1'b0;
    res_if.res_data  = 8'd0;
    rst = 1'b1;
    ena = 1'b1;
    step();
    step();
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_fifo_count", fifo_count, 0);
    check("reset_res_ready", res_if.res_ready, 1);
    rst = 1'b0;

    push_word(8'hA5);
    check("a5_queued_count", fifo_count, 1);
    check("a5_tx_before_pop", tx, 1);
    step();
    check("a5_start_bit_at_e1", tx, 0);
    check("a5_popped_count", fifo_count, 0);
    repeat (FRAME - 1) step();
    check("a5_busy_last_tick", busy, 1);
    step();
    check("a5_busy_after_frame", busy, 0);

    b2b[0] = 8'h01; b2b[1] = 8'h80; b2b[2] = 8'hFF; b2b[3] = 8'h00;
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      push_word(b2b[i]);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    check("b2b_peak_count", peak, 3);
    wait_idle(5 * FRAME);

    sent = 0; seen_full = 0; n = 0;
    res_if.res_valid = 1'b1;
    res_if.res_data  = 8'($urandom);
    while (sent < 6 && n < 400) begin
      @(negedge clk);
      if (fifo_count == 3'(DEPTH) && res_if.res_ready === 1'b0) seen_full = 1;
      acc = res_if.res_ready;
      step();
      n++;
      if (acc) begin
        sent++;
        res_if.res_data = 8'($urandom);
      end
    end
    res_if.res_valid = 1'b0;
    check("full_backpressure_seen", seen_full, 1);
    check("held_words_accepted", sent, 6);
    wait_idle(8 * FRAME);

    push_word(8'h5A);
    push_word(8'($urandom));
    repeat (17) step();
    ena = 1'b0;
    tx_f  = tx;
    cnt_f = fifo_count;
    check("freeze_in_bit3_level", tx_f, 1);
    repeat (7) step();
    check("freeze_tx_held", tx, tx_f);
    check("freeze_count_held", fifo_count, cnt_f);
    check("freeze_res_ready_low", res_if.res_ready, 0);
    ena = 1'b1;
    wait_idle(4 * FRAME);

    push_word(8'($urandom));
    push_word(8'($urandom));
    push_word(8'($urandom));
    repeat (23) step();
    check("two_words_queued", fifo_count, 2);
    rst = 1'b1;
    step();
    check("midreset_tx", tx, 1);
    check("midreset_count", fifo_count, 0);
    check("midreset_busy", busy, 0);
    rst = 1'b0;
    tx_low = 0;
    repeat (3 * FRAME) begin
      step();
      if (tx === 1'b0) tx_low = 1;
    end
    check("no_tx_after_reset", tx_low, 0);

    repeat (400) begin
      res_if.res_valid = ($urandom_range(0, 3) == 0);
      res_if.res_data  = 8'($urandom);
      ena = ($urandom_range(0, 9) != 0);
      step();
    end
    res_if.res_valid = 1'b0;
    ena = 1'b1;
    wait_idle(8 * FRAME);

    check("scoreboard_drained", exp_q.size(), 0);
    check("no_gap_with_pending_word", gap_err, 0);
    check("tx_frozen_when_disabled", frz_err, 0);
    check("no_unexpected_frame", unexp, 0);
    check("res_ready_rule", rdy_err, 0);
    check("frames_min", (frames >= 13) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
